// File: rtl/dfr_pkg.sv
// dfr_pkg: shared types and constants for the DFR phase sequencer.
//   PHASE_*      : encoding of the phase output bus
//   phase_t      : phase enum built on PHASE_*
//   seq_state_t  : sequencer FSM state encoding
//   state_phase(): maps an FSM state to the phase it presents downstream
package dfr_pkg;

    localparam logic [1:0] PHASE_IDLE  = 2'd0;
    localparam logic [1:0] PHASE_INIT  = 2'd1;
    localparam logic [1:0] PHASE_TRAIN = 2'd2;
    localparam logic [1:0] PHASE_TEST  = 2'd3;

    typedef enum logic [1:0] {
        PH_IDLE  = PHASE_IDLE,
        PH_INIT  = PHASE_INIT,
        PH_TRAIN = PHASE_TRAIN,
        PH_TEST  = PHASE_TEST
    } phase_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_INIT  = 3'd2,
        ST_TRAIN = 3'd3,
        ST_TEST  = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_t;

    function automatic phase_t state_phase(input seq_state_t s);
        phase_t p;
        case (s)
            ST_INIT:  p = PH_INIT;
            ST_TRAIN: p = PH_TRAIN;
            ST_TEST:  p = PH_TEST;
            default:  p = PH_IDLE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/dfr_step_counter.sv
// dfr_step_counter: step-within-sample, sample index and phase step count
// for the phase currently being sequenced. Limits are driven by the owner
// and may change whenever clear is asserted.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   clear             : zero all counters (wins over advance)
//   advance           : one step consumed
//   spp               : steps per sample (0 behaves as 1)
//   num_samples       : sample-index wrap (0 behaves as 1)
//   num_steps         : total steps in the phase (nonzero while in use)
//   step_idx          : step within the current sample
//   sample_idx        : current sample, truncated to SAMPLE_IDX_W
//   last_step         : the step being presented is the last of the phase
module dfr_step_counter #(
    parameter int CNT_W        = 32,
    parameter int SAMPLE_IDX_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    advance,
    input  logic [CNT_W-1:0]        spp,
    input  logic [CNT_W-1:0]        num_samples,
    input  logic [CNT_W-1:0]        num_steps,
    output logic [CNT_W-1:0]        step_idx,
    output logic [SAMPLE_IDX_W-1:0] sample_idx,
    output logic                    last_step
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] step_q,   step_d;
    logic [CNT_W-1:0] sample_q, sample_d;
    logic [CNT_W-1:0] taken_q,  taken_d;
    logic [CNT_W-1:0] spp_eff;
    logic [CNT_W-1:0] samples_eff;

    assign spp_eff     = (spp == '0) ? ONE : spp;
    assign samples_eff = (num_samples == '0) ? ONE : num_samples;

    always_comb begin
        step_d   = step_q;
        sample_d = sample_q;
        taken_d  = taken_q;
        if (clear) begin
            step_d   = '0;
            sample_d = '0;
            taken_d  = '0;
        end else if (advance) begin
            taken_d = taken_q + ONE;
            if (step_q == spp_eff - ONE) begin
                step_d   = '0;
                // Wrap compare uses the full-width counter, not the truncated output.
                sample_d = (sample_q == samples_eff - ONE) ? '0 : sample_q + ONE;
            end else begin
                step_d = step_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q   <= '0;
            sample_q <= '0;
            taken_q  <= '0;
        end else begin
            step_q   <= step_d;
            sample_q <= sample_d;
            taken_q  <= taken_d;
        end
    end

    assign step_idx   = step_q;
    assign sample_idx = sample_q[SAMPLE_IDX_W-1:0];
    assign last_step  = (taken_q == num_steps - ONE);

endmodule

// File: rtl/dfr_phase_sequencer.sv
// dfr_phase_sequencer: runs one DFR sequence INIT -> TRAIN -> TEST, issuing
// one valid/ready step per reservoir update, with busy/done status for the
// configuration block.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   start                   : one-cycle start pulse, ignored while busy
//   num_{init,train,test}_samples / _steps : per-phase run lengths
//   num_steps_per_sample    : steps before sample_idx advances
//   step_ready / step_valid : step handshake
//   phase, sample_idx, step_idx, first_step : step descriptor
//   busy, done              : run status, done is a one-cycle pulse
//   stall_cycles            : only with DFR_SEQ_STALL_CNT_EN defined; counts
//                             busy cycles where a step waited on step_ready
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; shadow registers load on start
// ST_ARM   | busy; picks the first phase with a nonzero step count
// ST_INIT  | presenting reservoir warm-up steps
// ST_TRAIN | presenting training steps
// ST_TEST  | presenting test steps
// ST_DONE  | one cycle, done=1 busy=1, then back to idle
module dfr_phase_sequencer
    import dfr_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int SAMPLE_IDX_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_init_samples,
    input  logic [CNT_W-1:0]        num_init_steps,
    input  logic [CNT_W-1:0]        num_train_samples,
    input  logic [CNT_W-1:0]        num_train_steps,
    input  logic [CNT_W-1:0]        num_test_samples,
    input  logic [CNT_W-1:0]        num_test_steps,
    input  logic [CNT_W-1:0]        num_steps_per_sample,
    input  logic                    step_ready,
    output logic                    step_valid,
    output logic [1:0]              phase,
    output logic [SAMPLE_IDX_W-1:0] sample_idx,
    output logic [CNT_W-1:0]        step_idx,
    output logic                    first_step,
    output logic                    busy,
`ifdef DFR_SEQ_STALL_CNT_EN
    output logic [CNT_W-1:0]        stall_cycles,
`endif
    output logic                    done
);

    seq_state_t state_q, state_d;

    logic [CNT_W-1:0] init_samples_q,  init_samples_d;
    logic [CNT_W-1:0] init_steps_q,    init_steps_d;
    logic [CNT_W-1:0] train_samples_q, train_samples_d;
    logic [CNT_W-1:0] train_steps_q,   train_steps_d;
    logic [CNT_W-1:0] test_samples_q,  test_samples_d;
    logic [CNT_W-1:0] test_steps_q,    test_steps_d;
    logic [CNT_W-1:0] spp_q,           spp_d;

    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   valid_q, valid_d;
    phase_t phase_q, phase_d;

    logic             accept_start;
    logic             cnt_clear;
    logic             cnt_advance;
    logic             cnt_last;
    logic [CNT_W-1:0] lim_samples;
    logic [CNT_W-1:0] lim_steps;
    seq_state_t       after_init;
    seq_state_t       after_train;
    seq_state_t       first_phase;

    assign accept_start = (state_q == ST_IDLE) && start;

    // Shadow copies of the run lengths, frozen for the whole run.
    always_comb begin
        init_samples_d  = init_samples_q;
        init_steps_d    = init_steps_q;
        train_samples_d = train_samples_q;
        train_steps_d   = train_steps_q;
        test_samples_d  = test_samples_q;
        test_steps_d    = test_steps_q;
        spp_d           = spp_q;
        if (accept_start) begin
            init_samples_d  = num_init_samples;
            init_steps_d    = num_init_steps;
            train_samples_d = num_train_samples;
            train_steps_d   = num_train_steps;
            test_samples_d  = num_test_samples;
            test_steps_d    = num_test_steps;
            spp_d           = num_steps_per_sample;
        end
    end

    // Phase skipping: phases with zero steps are never entered.
    always_comb begin
        after_train = (test_steps_q != '0) ? ST_TEST : ST_DONE;
        after_init  = (train_steps_q != '0) ? ST_TRAIN : after_train;
        first_phase = (init_steps_q != '0) ? ST_INIT : after_init;
    end

    always_comb begin
        lim_samples = '0;
        lim_steps   = '0;
        case (state_q)
            ST_INIT: begin
                lim_samples = init_samples_q;
                lim_steps   = init_steps_q;
            end
            ST_TRAIN: begin
                lim_samples = train_samples_q;
                lim_steps   = train_steps_q;
            end
            ST_TEST: begin
                lim_samples = test_samples_q;
                lim_steps   = test_steps_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_clear = 1'b1;
                if (start) state_d = ST_ARM;
            end
            ST_ARM: begin
                cnt_clear = 1'b1;
                state_d   = first_phase;
            end
            ST_INIT, ST_TRAIN, ST_TEST: begin
                cnt_advance = step_ready;
                if (step_ready && cnt_last) begin
                    cnt_clear = 1'b1;
                    case (state_q)
                        ST_INIT:  state_d = after_init;
                        ST_TRAIN: state_d = after_train;
                        default:  state_d = ST_DONE;
                    endcase
                end
            end
            ST_DONE: begin
                cnt_clear = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                cnt_clear = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they change only on edges.
    always_comb begin
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        phase_d = state_phase(state_d);
        valid_d = (phase_d != PH_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            init_samples_q  <= '0;
            init_steps_q    <= '0;
            train_samples_q <= '0;
            train_steps_q   <= '0;
            test_samples_q  <= '0;
            test_steps_q    <= '0;
            spp_q           <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            valid_q         <= 1'b0;
            phase_q         <= PH_IDLE;
        end else begin
            state_q         <= state_d;
            init_samples_q  <= init_samples_d;
            init_steps_q    <= init_steps_d;
            train_samples_q <= train_samples_d;
            train_steps_q   <= train_steps_d;
            test_samples_q  <= test_samples_d;
            test_steps_q    <= test_steps_d;
            spp_q           <= spp_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            valid_q         <= valid_d;
            phase_q         <= phase_d;
        end
    end

    dfr_step_counter #(
        .CNT_W        (CNT_W),
        .SAMPLE_IDX_W (SAMPLE_IDX_W)
    ) u_step_counter (
        .clk         (clk),
        .rst         (rst),
        .clear       (cnt_clear),
        .advance     (cnt_advance),
        .spp         (spp_q),
        .num_samples (lim_samples),
        .num_steps   (lim_steps),
        .step_idx    (step_idx),
        .sample_idx  (sample_idx),
        .last_step   (cnt_last)
    );

`ifdef DFR_SEQ_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (accept_start) begin
            stall_d = '0;
        end else if (busy_q && valid_q && !step_ready && (stall_q != '1)) begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif

    assign step_valid = valid_q;
    assign phase      = phase_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign first_step = valid_q && (step_idx == '0);

endmodule

// File: tb/tb_dfr_phase_sequencer.sv
module tb_dfr_phase_sequencer;

    localparam int CNT_W = 32;
    localparam int SIW   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_init_samples, num_init_steps;
    logic [CNT_W-1:0] num_train_samples, num_train_steps;
    logic [CNT_W-1:0] num_test_samples, num_test_steps;
    logic [CNT_W-1:0] num_steps_per_sample;
    logic             step_ready;
    logic             step_valid;
    logic [1:0]       phase;
    logic [SIW-1:0]   sample_idx;
    logic [CNT_W-1:0] step_idx;
    logic             first_step;
    logic             busy;
    logic             done;
`ifdef DFR_SEQ_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dfr_phase_sequencer #(.CNT_W(CNT_W), .SAMPLE_IDX_W(SIW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .num_init_samples     (num_init_samples),
        .num_init_steps       (num_init_steps),
        .num_train_samples    (num_train_samples),
        .num_train_steps      (num_train_steps),
        .num_test_samples     (num_test_samples),
        .num_test_steps       (num_test_steps),
        .num_steps_per_sample (num_steps_per_sample),
        .step_ready           (step_ready),
        .step_valid           (step_valid),
        .phase                (phase),
        .sample_idx           (sample_idx),
        .step_idx             (step_idx),
        .first_step           (first_step),
        .busy                 (busy),
`ifdef DFR_SEQ_STALL_CNT_EN
        .stall_cycles         (stall_cycles),
`endif
        .done                 (done)
    );

    typedef struct {
        logic rdy;
        logic valid;
        int   ph;
        int   smp;
        int   stp;
        logic bsy;
        logic dn;
    } vec_t;

    typedef struct {
        int ph;
        int smp;
        int stp;
    } step_t;

    vec_t  main_v[$];
    vec_t  stall_v[$];
    step_t exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rdy, input logic valid, input int ph,
                                input int smp, input int stp, input logic bsy, input logic dn);
        vec_t v;
        v.rdy = rdy; v.valid = valid; v.ph = ph; v.smp = smp; v.stp = stp;
        v.bsy = bsy; v.dn = dn;
        return v;
    endfunction

    // Reference sequence: step k of a phase is step k%spp of sample (k/spp)%ns.
    function automatic void model(input int is, input int isamp, input int ts, input int tsamp,
                                  input int es, input int esamp, input int spp);
        int steps[3];
        int samps[3];
        int spp_e;
        step_t s;
        steps[0] = is; steps[1] = ts; steps[2] = es;
        samps[0] = (isamp == 0) ? 1 : isamp;
        samps[1] = (tsamp == 0) ? 1 : tsamp;
        samps[2] = (esamp == 0) ? 1 : esamp;
        spp_e = (spp == 0) ? 1 : spp;
        exp_q.delete();
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < steps[p]; k++) begin
                s.ph  = p + 1;
                s.smp = (k / spp_e) % samps[p];
                s.stp = k % spp_e;
                exp_q.push_back(s);
            end
        end
    endfunction

    task automatic set_counts(input int is, input int isamp, input int ts, input int tsamp,
                              input int es, input int esamp, input int spp);
        num_init_steps       = is;
        num_init_samples     = isamp;
        num_train_steps      = ts;
        num_train_samples    = tsamp;
        num_test_steps       = es;
        num_test_samples     = esamp;
        num_steps_per_sample = spp;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic apply_vec(input string name, input vec_t v);
        chk({name, " valid"}, step_valid, v.valid);
        chk({name, " busy"},  busy,       v.bsy);
        chk({name, " done"},  done,       v.dn);
        chk({name, " phase"}, phase,      v.ph);
        if (v.valid) begin
            chk({name, " sample"}, sample_idx, v.smp);
            chk({name, " step"},   step_idx,   v.stp);
            chk({name, " first"},  first_step, (v.stp == 0) ? 1 : 0);
        end
        step_ready = v.rdy;
        tick();
    endtask

    // Run with ready held high, compare every presented step against exp_q.
    // When inject_at >= 0, a second start and new counts are driven once
    // that many steps have been presented.
    task automatic run_seq(input string name, input int inject_at);
        int  n;
        bit  seen_done;
        bit  injected;
        n = 0; seen_done = 0; injected = 0;
        step_ready = 1'b1;
        for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
            if (step_valid) begin
                if (n < exp_q.size()) begin
                    chk({name, " phase"},  phase,      exp_q[n].ph);
                    chk({name, " sample"}, sample_idx, exp_q[n].smp);
                    chk({name, " step"},   step_idx,   exp_q[n].stp);
                end else begin
                    chk({name, " extra step"}, n, exp_q.size());
                end
                n++;
            end
            if (done) seen_done = 1;
            if (!injected && inject_at >= 0 && n == inject_at) begin
                injected = 1;
                start = 1'b1;
                set_counts(9, 9, 9, 9, 9, 9, 3);
            end
            tick();
            start = 1'b0;
        end
        chk({name, " step count"}, n, exp_q.size());
        chk({name, " done seen"},  seen_done, 1);
        chk({name, " busy after"}, busy, 0);
    endtask

    initial begin
        int tcnt;
        int vcnt;
        rst = 1'b1;
        start = 1'b0;
        step_ready = 1'b0;
        set_counts(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("reset valid", step_valid, 0);
        chk("reset busy",  busy, 0);
        chk("reset done",  done, 0);
        chk("reset phase", phase, 0);
        chk("reset sample", sample_idx, 0);
        chk("reset step",  step_idx, 0);
        rst = 1'b0;
        tick();

        // Main run: INIT 4/2, TRAIN 6/3, TEST 2/1, spp=2.
        main_v.push_back(mk(1, 0, 0, 0, 0, 1, 0));
        main_v.push_back(mk(1, 1, 1, 0, 0, 1, 0));
        main_v.push_back(mk(1, 1, 1, 0, 1, 1, 0));
        main_v.push_back(mk(1, 1, 1, 1, 0, 1, 0));
        main_v.push_back(mk(1, 1, 1, 1, 1, 1, 0));
        main_v.push_back(mk(1, 1, 2, 0, 0, 1, 0));
        main_v.push_back(mk(1, 1, 2, 0, 1, 1, 0));
        main_v.push_back(mk(1, 1, 2, 1, 0, 1, 0));
        main_v.push_back(mk(1, 1, 2, 1, 1, 1, 0));
        main_v.push_back(mk(1, 1, 2, 2, 0, 1, 0));
        main_v.push_back(mk(1, 1, 2, 2, 1, 1, 0));
        main_v.push_back(mk(1, 1, 3, 0, 0, 1, 0));
        main_v.push_back(mk(1, 1, 3, 0, 1, 1, 0));
        main_v.push_back(mk(1, 0, 0, 0, 0, 1, 1));
        main_v.push_back(mk(1, 0, 0, 0, 0, 0, 0));

        // TRAIN only, 3 steps/3 samples, spp=1, ready 1-0-0-1-1.
        stall_v.push_back(mk(1, 0, 0, 0, 0, 1, 0));
        stall_v.push_back(mk(1, 1, 2, 0, 0, 1, 0));
        stall_v.push_back(mk(0, 1, 2, 1, 0, 1, 0));
        stall_v.push_back(mk(0, 1, 2, 1, 0, 1, 0));
        stall_v.push_back(mk(1, 1, 2, 1, 0, 1, 0));
        stall_v.push_back(mk(1, 1, 2, 2, 0, 1, 0));
        stall_v.push_back(mk(1, 0, 0, 0, 0, 1, 1));
        stall_v.push_back(mk(1, 0, 0, 0, 0, 0, 0));

        set_counts(4, 2, 6, 3, 2, 1, 2);
        step_ready = 1'b1;
        pulse_start();
        foreach (main_v[i]) apply_vec($sformatf("main[%0d]", i), main_v[i]);

        set_counts(0, 0, 3, 3, 0, 0, 1);
        pulse_start();
`ifdef DFR_SEQ_STALL_CNT_EN
        chk("stall cleared on start", stall_cycles, 0);
`endif
        foreach (stall_v[i]) apply_vec($sformatf("stall[%0d]", i), stall_v[i]);
`ifdef DFR_SEQ_STALL_CNT_EN
        chk("stall count held", stall_cycles, 2);
`endif

        // All-zero counts: ARM, then DONE, never a valid step.
        set_counts(0, 5, 0, 5, 0, 5, 4);
        pulse_start();
        chk("zero arm busy",   busy, 1);
        chk("zero arm valid",  step_valid, 0);
        chk("zero arm done",   done, 0);
        tick();
        chk("zero done pulse", done, 1);
        chk("zero done busy",  busy, 1);
        chk("zero done valid", step_valid, 0);
        tick();
        chk("zero idle busy",  busy, 0);
        chk("zero idle done",  done, 0);

        // Second start and count changes mid-TRAIN are ignored.
        set_counts(2, 1, 4, 2, 2, 1, 2);
        model(2, 1, 4, 2, 2, 1, 2);
        pulse_start();
        run_seq("midstart", 4);

        // Sample wrap with TRAIN only.
        set_counts(0, 0, 10, 2, 0, 0, 2);
        model(0, 0, 10, 2, 0, 0, 2);
        pulse_start();
        run_seq("wrap", -1);

        // Reset at the third TRAIN step aborts without done.
        set_counts(2, 1, 4, 2, 2, 1, 2);
        step_ready = 1'b1;
        pulse_start();
        tcnt = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (step_valid && phase == 2) tcnt++;
            if (tcnt == 3) break;
            tick();
        end
        chk("rst reached third train", tcnt, 3);
        rst = 1'b1;
        tick();
        chk("rst phase", phase, 0);
        chk("rst busy",  busy, 0);
        chk("rst valid", step_valid, 0);
        chk("rst done",  done, 0);
        rst = 1'b0;
        vcnt = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            tick();
            if (done || step_valid || busy) vcnt++;
        end
        chk("rst stays idle", vcnt, 0);

        set_counts(4, 2, 6, 3, 2, 1, 2);
        model(4, 2, 6, 3, 2, 1, 2);
        pulse_start();
        run_seq("after rst", -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dfr_phase_sequencer.md
Name: dfr_phase_sequencer

Overview:
- Sits directly downstream of the AXI configuration register block and consumes its start bit and run-length registers: start pulse, init/train/test sample and step counts, and steps per sample.
- Sequences one DFR run through three phases in order: INIT (reservoir warm-up), TRAIN, TEST.
- For every reservoir step it issues a valid/ready handshake carrying the phase, sample index and step-within-sample to the reservoir/memory datapath.
- Returns the busy flag that the configuration block mirrors into ctrl bit 1.

Parameters:
- CNT_W, 32, width of all count inputs and index outputs (matches the 32-bit config registers)
- SAMPLE_IDX_W, 16, width of sample_idx (matches the 16-bit memory address space)

Ports:
- clk  in  1  system clock, same domain as the configuration registers
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle start pulse (ctrl bit 0)
- num_init_samples  in  CNT_W  sample-index wrap for INIT
- num_init_steps  in  CNT_W  total steps in INIT
- num_train_samples  in  CNT_W  sample-index wrap for TRAIN
- num_train_steps  in  CNT_W  total steps in TRAIN
- num_test_samples  in  CNT_W  sample-index wrap for TEST
- num_test_steps  in  CNT_W  total steps in TEST
- num_steps_per_sample  in  CNT_W  steps before sample_idx advances
- step_ready  in  1  downstream accepts the current step
- step_valid  out  1  a step is presented
- phase  out  2  0=IDLE, 1=INIT, 2=TRAIN, 3=TEST
- sample_idx  out  SAMPLE_IDX_W  current sample within the phase
- step_idx  out  CNT_W  step within the current sample
- first_step  out  1  high with step_valid on step_idx==0
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when the run completes

Behaviour:
- Reset: all outputs are 0, state is IDLE, and every counter is cleared.
- Reset mid-run aborts the run on the next edge; done is not pulsed.
- State machine: IDLE -> INIT -> TRAIN -> TEST -> DONE -> IDLE.
- IDLE:
  - When start=1, latch all count inputs into internal shadow registers.
  - busy rises the following cycle.
  - The next state is the first phase whose step count is nonzero; if all three are 0, go straight to DONE.
- start while busy=1 is ignored. Shadow registers are never updated mid-run.
- Phase states (INIT, TRAIN, TEST):
  - step_valid=1 continuously.
  - A step is consumed on step_valid && step_ready.
  - On consume, step_idx increments.
  - When step_idx reaches spp-1 (spp = num_steps_per_sample, with 0 treated as 1), step_idx goes to 0 and sample_idx increments.
  - sample_idx wraps to 0 on reaching num_X_samples-1; num_X_samples of 0 is treated as 1.
  - Phase step counter: when it reaches num_X_steps-1 on a consume, move to the next phase with nonzero steps, or to DONE. step_idx and sample_idx reset to 0 at each phase change.
- Outputs (step_idx, sample_idx, phase) are registered and hold stable while step_valid && !step_ready.
- step_valid stays high across a phase boundary with no bubble; the first step of the new phase is presented the cycle after the last consume.
- DONE lasts one cycle: done=1 and busy=1 in that cycle. busy drops the cycle after, in IDLE.
- sample_idx is truncated to SAMPLE_IDX_W. Wrap arithmetic uses the full CNT_W shadow value, and the comparison is on the untruncated internal counter.
- Throughput is one step per cycle when step_ready is held high.

Optional Feature:
- Macro: DFR_SEQ_STALL_CNT_EN
- Defined:
  - Adds output stall_cycles (CNT_W).
  - Counts cycles with busy && step_valid && !step_ready, saturating at all-ones.
  - Cleared on rst and on an accepted start.
  - Holds its value after done until the next start.
- Undefined: the port and the counter are absent.

Decomposition:
- Package dfr_pkg holds:
  - phase_t enum (IDLE/INIT/TRAIN/TEST, 2 bits)
  - seq_state_t enum
  - PHASE_* constants
- One sub-module, dfr_step_counter:
  - Contains the step_idx / sample_idx / phase-step-count triple.
  - Inputs: advance, clear, spp, num_samples, num_steps.
  - Outputs: indices plus a last_step flag.
  - The top FSM instantiates it once and reloads its limits per phase.

Test Plan:
- INIT=4 steps/2 samples, TRAIN=6/3, TEST=2/1, spp=2, step_ready=1, then start -> 12 consecutive valid cycles:
  - INIT sample_idx 0,0,1,1
  - TRAIN 0,0,1,1,2,2
  - TEST 0,0
  - done pulses one cycle after the last step; busy is high for 14 cycles total.
- INIT steps=0, TRAIN 3 steps, TEST steps=0 -> only phase=2 is ever presented; all-zero counts -> done two cycles after start, step_valid never asserts.
- step_ready toggled 1-0-0-1 pattern -> indices are held during stall cycles, no step is skipped or duplicated; with DFR_SEQ_STALL_CNT_EN, stall_cycles equals the number of low-ready cycles.
- Second start pulse and count changes mid-TRAIN -> ignored; the run completes with the original counts.
- rst asserted at the third TRAIN step -> next cycle phase=0, busy=0, step_valid=0, no done; a subsequent start runs the full sequence correctly.
- sample wrap: TRAIN steps=10, samples=2, spp=2 -> sample_idx sequence 0,0,1,1,0,0,1,1,0,0.
